uart_rx_cfg: RTL and testbench

Parametrised successor to the UART receiver. It deserialises one asynchronous serial line using an externally generated oversampling tick (i_tick). Word length, oversampling ratio and stop length are configurable. Adds an input synchroniser, false-start rejection, framing-error detection, and a valid/ready output handshake with overrun detection. It sits between the baud-rate generator and the RX FIFO or command interface.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_sync_ff.sv | 25 ++
 rtl/uart_rx_cfg.sv | 181 ++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART blocks: receiver state encoding,
// line idle level and counter-width helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam logic LINE_IDLE = 1'b1;

    // Bits needed to count 0 .. max(a, b)-1.
    function automatic int clog2_max(input int a, input int b);
        return (a > b) ? $clog2(a) : $clog2(b);
    endfunction

endpackage

// File: rtl/uart_sync_ff.sv
// Multi-stage synchroniser for asynchronous single-bit inputs, with a
// configurable reset level so an idle line never looks active out of reset.
module sync_ff #(
    parameter int   NB_SYNC = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [NB_SYNC-1:0] sync_q;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= {NB_SYNC{RST_VAL}};
        end else begin
            sync_q <= {sync_q[NB_SYNC-2:0], i_d};
        end
    end

    assign o_q = sync_q[NB_SYNC-1];

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable oversampling UART receiver with valid/ready output, framing
// and overrun reporting. Define UART_RX_PARITY_EN to add a parity bit check.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int NB_DATA    = 8,
    parameter int OVERSAMPLE = 16,
    parameter int NB_STOP    = 16,
    parameter int NB_SYNC    = 2
`ifdef UART_RX_PARITY_EN
    ,
    parameter int PARITY_ODD = 0
`endif
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_tick,
    input  logic               i_data,
    input  logic               i_ready,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_valid,
    output logic               o_rxdone,
    output logic               o_frame_err,
    output logic               o_overrun,
    output logic               o_busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic               o_parity_err
`endif
);

    localparam int CNT_W  = clog2_max(OVERSAMPLE, NB_STOP);
    localparam int NBIT_W = $clog2(NB_DATA);

    localparam logic [CNT_W-1:0]  MID_CNT  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0]  BIT_CNT  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0]  STOP_CNT = CNT_W'(NB_STOP - 1);
    localparam logic [NBIT_W-1:0] LAST_BIT = NBIT_W'(NB_DATA - 1);

`ifdef UART_RX_PARITY_EN
    localparam rx_state_e AFTER_DATA = PARITY;
`else
    localparam rx_state_e AFTER_DATA = STOP;
`endif

    rx_state_e          state;
    logic [CNT_W-1:0]   s_cnt;
    logic [NBIT_W-1:0]  n_cnt;
    logic [NB_DATA-1:0] shreg;
    logic               wait_high;
    logic               rx_s;
`ifdef UART_RX_PARITY_EN
    logic               par_bit;
`endif

    sync_ff #(
        .NB_SYNC (NB_SYNC),
        .RST_VAL (LINE_IDLE)
    ) u_sync (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_data),
        .o_q     (rx_s)
    );

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            s_cnt       <= '0;
            n_cnt       <= '0;
            shreg       <= '0;
            wait_high   <= 1'b0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_rxdone    <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
            o_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit      <= 1'b0;
            o_parity_err <= 1'b0;
`endif
        end else begin
            // NOTE: pulses default low here; a later non-blocking write in this block wins.
            o_rxdone  <= 1'b0;
            o_overrun <= 1'b0;
            if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (rx_s == LINE_IDLE) begin
                        wait_high <= 1'b0;
                    end else if (!wait_high) begin
                        state  <= START;
                        s_cnt  <= '0;
                        o_busy <= 1'b1;
                    end
                end

                START: begin
                    if (i_tick) begin
                        if (s_cnt == MID_CNT) begin
                            if (rx_s == LINE_IDLE) begin
                                state  <= IDLE;
                                o_busy <= 1'b0;
                            end else begin
                                state <= DATA;
                                s_cnt <= '0;
                                n_cnt <= '0;
                            end
                        end else begin
                            s_cnt <= s_cnt + 1'b1;
                        end
                    end
                end

                DATA: begin
                    if (i_tick) begin
                        if (s_cnt == BIT_CNT) begin
                            s_cnt <= '0;
                            shreg <= {rx_s, shreg[NB_DATA-1:1]};
                            n_cnt <= n_cnt + 1'b1;
                            if (n_cnt == LAST_BIT) begin
                                state <= AFTER_DATA;
                            end
                        end else begin
                            s_cnt <= s_cnt + 1'b1;
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (i_tick) begin
                        if (s_cnt == BIT_CNT) begin
                            s_cnt   <= '0;
                            par_bit <= rx_s;
                            state   <= STOP;
                        end else begin
                            s_cnt <= s_cnt + 1'b1;
                        end
                    end
                end
`endif

                STOP: begin
                    if (i_tick) begin
                        if (s_cnt == STOP_CNT) begin
                            state       <= IDLE;
                            o_busy      <= 1'b0;
                            s_cnt       <= '0;
                            o_rxdone    <= 1'b1;
                            o_frame_err <= (rx_s != LINE_IDLE);
                            // A low stop sample means the line may be in break; re-arm only after it idles.
                            wait_high   <= (rx_s != LINE_IDLE);
`ifdef UART_RX_PARITY_EN
                            o_parity_err <= (^shreg) ^ par_bit ^ (PARITY_ODD != 0);
`endif
                            if (!o_valid || i_ready) begin
                                o_data  <= shreg;
                                o_valid <= 1'b1;
                            end else begin
                                o_overrun <= 1'b1;
                            end
                        end else begin
                            s_cnt <= s_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: a default 8N1/16x instance and a
// 7-bit/8x instance, fed with directed frames and hand-computed expectations.
module tb_uart_rx_cfg;

    localparam int CLK_HALF = 5;
    localparam int TICK_DIV = 4;
    localparam int OS_A     = 16;
    localparam int NB_A     = 8;
    localparam int OS_B     = 8;
    localparam int NB_B     = 7;
    localparam int NSTOP    = 16;
`ifdef UART_RX_PARITY_EN
    localparam int B_TICKS  = OS_B / 2 + NB_B * OS_B + OS_B + NSTOP;
    localparam int A_BITS   = NB_A + 3;
`else
    localparam int B_TICKS  = OS_B / 2 + NB_B * OS_B + NSTOP;
    localparam int A_BITS   = NB_A + 2;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tick = 1'b0;
    logic line_a = 1'b1;
    logic line_b = 1'b1;
    logic ready_a = 1'b1;
    logic ready_b = 1'b1;

    logic [NB_A-1:0] data_a;
    logic [NB_B-1:0] data_b;
    logic valid_a, rxdone_a, ferr_a, ovr_a, busy_a;
    logic valid_b, rxdone_b, ferr_b, ovr_b, busy_b;
`ifdef UART_RX_PARITY_EN
    logic perr_a, perr_b;
`endif

    uart_rx_cfg #(
        .NB_DATA    (NB_A),
        .OVERSAMPLE (OS_A),
        .NB_STOP    (NSTOP),
        .NB_SYNC    (2)
    ) dut_a (
        .clk         (clk),
        .i_rst_n     (rst_n),
        .i_tick      (tick),
        .i_data      (line_a),
        .i_ready     (ready_a),
        .o_data      (data_a),
        .o_valid     (valid_a),
        .o_rxdone    (rxdone_a),
        .o_frame_err (ferr_a),
        .o_overrun   (ovr_a),
        .o_busy      (busy_a)
`ifdef UART_RX_PARITY_EN
        ,
        .o_parity_err (perr_a)
`endif
    );

    uart_rx_cfg #(
        .NB_DATA    (NB_B),
        .OVERSAMPLE (OS_B),
        .NB_STOP    (NSTOP),
        .NB_SYNC    (2)
    ) dut_b (
        .clk         (clk),
        .i_rst_n     (rst_n),
        .i_tick      (tick),
        .i_data      (line_b),
        .i_ready     (ready_b),
        .o_data      (data_b),
        .o_valid     (valid_b),
        .o_rxdone    (rxdone_b),
        .o_frame_err (ferr_b),
        .o_overrun   (ovr_b),
        .o_busy      (busy_b)
`ifdef UART_RX_PARITY_EN
        ,
        .o_parity_err (perr_b)
`endif
    );

    always #CLK_HALF clk = ~clk;

    // One-clk tick every TICK_DIV clocks, driven away from the active edge.
    int tick_phase = 0;
    always @(negedge clk) begin
        tick_phase = (tick_phase + 1) % TICK_DIV;
        tick = (tick_phase == 0);
    end

    int unsigned tick_cnt = 0;
    always @(posedge clk) begin
        if (tick) tick_cnt <= tick_cnt + 1;
    end

    typedef struct {
        logic ferr;
        logic ovr;
        logic perr;
    } frame_exp_t;

    frame_exp_t      frame_q[$];
    logic [NB_A-1:0] data_q[$];
    logic [NB_B-1:0] data_b_q[$];
    int              b_pending = 0;
    int unsigned     edge_tick_b = 0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: output event with nothing expected", name);
    endtask

    // Monitor for instance A: completion flags on o_rxdone, payload on handshake.
    always @(negedge clk) begin
        frame_exp_t fe;
        #2;
        if (rst_n) begin
            if (rxdone_a) begin
                if (frame_q.size() == 0) begin
                    unexpected("a_rxdone");
                end else begin
                    fe = frame_q.pop_front();
                    check("a_frame_err", 32'(ferr_a), 32'(fe.ferr));
                    check("a_overrun", 32'(ovr_a), 32'(fe.ovr));
`ifdef UART_RX_PARITY_EN
                    check("a_parity_err", 32'(perr_a), 32'(fe.perr));
`endif
                end
            end else if (ovr_a) begin
                unexpected("a_overrun_stray");
            end
            if (valid_a && ready_a) begin
                if (data_q.size() == 0) unexpected("a_handshake");
                else check("a_data", 32'(data_a), 32'(data_q.pop_front()));
            end
        end
    end

    // Monitor for instance B, including frame length measured in ticks.
    always @(negedge clk) begin
        int unsigned lat;
        #2;
        if (rst_n) begin
            if (rxdone_b) begin
                if (b_pending == 0) begin
                    unexpected("b_rxdone");
                end else begin
                    b_pending--;
                    check("b_frame_err", 32'(ferr_b), 32'(1'b0));
                    lat = tick_cnt - edge_tick_b;
                    checks++;
                    // Start detection can lose at most one tick to synchroniser latency.
                    if (lat < B_TICKS || lat > B_TICKS + 1) begin
                        errors++;
                        $display("FAIL b_frame_ticks: got %0d, expected %0d..%0d", lat, B_TICKS, B_TICKS + 1);
                    end
                end
            end
            if (valid_b && ready_b) begin
                if (data_b_q.size() == 0) unexpected("b_handshake");
                else check("b_data", 32'(data_b), 32'(data_b_q.pop_front()));
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_line(input int which, input logic v);
        if (which == 0) line_a = v;
        else line_b = v;
    endtask

    task automatic send_frame(input int which, input logic [8:0] data, input int nbits,
                              input int os, input logic stop_bit
`ifdef UART_RX_PARITY_EN
                              , input logic par_flip = 1'b0
`endif
                              );
        int bit_clks;
`ifdef UART_RX_PARITY_EN
        logic par;
`endif
        bit_clks = os * TICK_DIV;
        drive_line(which, 1'b0);
        wait_clks(bit_clks);
        for (int i = 0; i < nbits; i++) begin
            drive_line(which, data[i]);
            wait_clks(bit_clks);
        end
`ifdef UART_RX_PARITY_EN
        par = 1'b0;
        for (int i = 0; i < nbits; i++) par ^= data[i];
        drive_line(which, par ^ par_flip);
        wait_clks(bit_clks);
`endif
        drive_line(which, stop_bit);
        wait_clks(NSTOP * TICK_DIV);
        drive_line(which, 1'b1);
        wait_clks(2 * bit_clks);
    endtask

    task automatic expect_a(input logic [7:0] d, input logic ferr, input logic ovr,
                            input logic perr, input logic delivered);
        frame_exp_t fe;
        fe.ferr = ferr;
        fe.ovr  = ovr;
        fe.perr = perr;
        frame_q.push_back(fe);
        if (delivered) data_q.push_back(d);
    endtask

    task automatic check_a_idle_outputs(input string tag);
        check({tag, "_data"},   32'(data_a),   32'h0);
        check({tag, "_valid"},  32'(valid_a),  32'h0);
        check({tag, "_rxdone"}, 32'(rxdone_a), 32'h0);
        check({tag, "_ferr"},   32'(ferr_a),   32'h0);
        check({tag, "_ovr"},    32'(ovr_a),    32'h0);
        check({tag, "_busy"},   32'(busy_a),   32'h0);
`ifdef UART_RX_PARITY_EN
        check({tag, "_perr"},   32'(perr_a),   32'h0);
`endif
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] aborted;
        int left;

        rst_n = 1'b0;
        wait_clks(3);
        #1;
        check_a_idle_outputs("reset");
        check("reset_b_valid", 32'(valid_b), 32'h0);
        check("reset_b_busy", 32'(busy_b), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_clks(8);

        // Back-to-back good frames.
        expect_a(8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(0, 9'h055, NB_A, OS_A, 1'b1);
        expect_a(8'hA3, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(0, 9'h0A3, NB_A, OS_A, 1'b1);

        // Glitch shorter than half a bit must be rejected silently.
        drive_line(0, 1'b0);
        wait_clks(5 * TICK_DIV);
        drive_line(0, 1'b1);
        wait_clks(OS_A * TICK_DIV);
        check("glitch_busy", 32'(busy_a), 32'h0);
        expect_a(8'h81, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(0, 9'h081, NB_A, OS_A, 1'b1);

        // Low stop bit: delivered with framing error, cleared by next good frame.
        expect_a(8'hF0, 1'b1, 1'b0, 1'b0, 1'b1);
        send_frame(0, 9'h0F0, NB_A, OS_A, 1'b0);
        expect_a(8'h12, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(0, 9'h012, NB_A, OS_A, 1'b1);

        // Consumer stalled: second word is dropped with an overrun pulse.
        ready_a = 1'b0;
        expect_a(8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(0, 9'h011, NB_A, OS_A, 1'b1);
        expect_a(8'h22, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(0, 9'h022, NB_A, OS_A, 1'b1);
        check("stall_valid", 32'(valid_a), 32'h1);
        check("stall_data", 32'(data_a), 32'h11);
        ready_a = 1'b1;
        wait_clks(1);
        ready_a = 1'b0;
        wait_clks(2);
        check("drain_valid", 32'(valid_a), 32'h0);
        ready_a = 1'b1;

        // Break: one all-zero errored frame, no re-arm while the line stays low.
        expect_a(8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        drive_line(0, 1'b0);
        wait_clks((A_BITS + 2) * OS_A * TICK_DIV);
        drive_line(0, 1'b1);
        wait_clks(2 * OS_A * TICK_DIV);
        check("break_busy", 32'(busy_a), 32'h0);
        expect_a(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(0, 9'h03C, NB_A, OS_A, 1'b1);

        // Reset during data bit 4 aborts the frame with no pulses.
        aborted = 8'h77;
        drive_line(0, 1'b0);
        wait_clks(OS_A * TICK_DIV);
        for (int i = 0; i < 4; i++) begin
            drive_line(0, aborted[i]);
            wait_clks(OS_A * TICK_DIV);
        end
        drive_line(0, aborted[4]);
        wait_clks(OS_A * TICK_DIV / 2);
        rst_n = 1'b0;
        #1;
        check_a_idle_outputs("midreset");
        wait_clks(3);
        drive_line(0, 1'b1);
        rst_n = 1'b1;
        wait_clks(OS_A * TICK_DIV);
        expect_a(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(0, 9'h05A, NB_A, OS_A, 1'b1);

`ifdef UART_RX_PARITY_EN
        // Corrupted parity flagged; next good frame clears the flag.
        expect_a(8'h5A, 1'b0, 1'b0, 1'b1, 1'b1);
        send_frame(0, 9'h05A, NB_A, OS_A, 1'b1, 1'b1);
        expect_a(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(0, 9'h0C3, NB_A, OS_A, 1'b1);
`endif

        // 7-bit, 8x-oversampled instance.
        data_b_q.push_back(7'h3C);
        b_pending = 1;
        edge_tick_b = tick_cnt;
        send_frame(1, 9'h03C, NB_B, OS_B, 1'b1);
        check("b_busy_after", 32'(busy_b), 32'h0);
        check("b_overrun", 32'(ovr_b), 32'h0);

        left = frame_q.size() + data_q.size() + data_b_q.size() + b_pending;
        for (int i = 0; i < 2000 && left != 0; i++) begin
            wait_clks(1);
            left = frame_q.size() + data_q.size() + data_b_q.size() + b_pending;
        end
        check("outstanding_expectations", 32'(left), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
